// File: rtl/dl_pkg.sv
// Shared types and defaults for the ROM download router.
package dl_pkg;

  localparam int unsigned ADDR_W_DEF  = 25;
  localparam int unsigned WORD_W      = 23;
  localparam logic [7:0]  ROM_IDX_DEF = 8'd0;
  localparam logic [7:0]  MOD_IDX_DEF = 8'd1;
  localparam logic [7:0]  DIP_IDX_DEF = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK
  } dl_state_e;

endpackage

// File: rtl/dl_window_match.sv
// Inclusive address window decode for one SDRAM port, plus the port-relative word address.
module dl_window_match
  import dl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [31:0] BASE   = 32'h0000_0000,
  parameter logic [31:0] LIMIT  = 32'hFFFF_FFFF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit_c,
  output logic [WORD_W-1:0] word_c
);

  logic [31:0] addr32;
  logic [32:0] lo_d;
  logic [32:0] hi_d;
  logic        unused_bits;

  // A borrow out of either subtraction means the address is outside the window.
  assign addr32 = 32'(addr);
  assign lo_d   = {1'b0, addr32} - {1'b0, BASE};
  assign hi_d   = {1'b0, LIMIT} - {1'b0, addr32};
  assign hit_c  = ~lo_d[32] & ~hi_d[32];
  assign word_c = lo_d[WORD_W:1];

  assign unused_bits = ^{lo_d[31:WORD_W+1], lo_d[0], hi_d[31:0]};

endmodule

// File: rtl/rom_dl_router.sv
// Routes HPS ioctl ROM bytes to up to four SDRAM write ports over a toggle
// handshake, captures mod/DIP bytes and stretches core reset after the load.
module rom_dl_router
  import dl_pkg::*;
#(
  parameter int unsigned                NUM_PORTS  = 2,
  parameter int unsigned                ADDR_W     = ADDR_W_DEF,
  parameter logic [NUM_PORTS-1:0][31:0] PORT_BASE  = {32'h0003_0000, 32'h0000_0000},
  parameter logic [NUM_PORTS-1:0][31:0] PORT_LIMIT = {32'h0009_FFFF, 32'h0009_FFFF},
  parameter logic [7:0]                 ROM_IDX    = ROM_IDX_DEF,
  parameter logic [7:0]                 MOD_IDX    = MOD_IDX_DEF,
  parameter logic [7:0]                 DIP_IDX    = DIP_IDX_DEF,
  parameter logic [15:0]                HOLD       = 16'hFFFF
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        ioctl_download,
  input  logic                        ioctl_wr,
  input  logic [7:0]                  ioctl_index,
  input  logic [ADDR_W-1:0]           ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  output logic                        ioctl_wait,
  output logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_ack,
  output logic [NUM_PORTS*WORD_W-1:0] port_a,
  output logic [1:0]                  port_ds,
  output logic [15:0]                 port_d,
  output logic                        port_we,
  input  logic                        user_reset,
  output logic [7:0]                  core_mod,
  output logic [63:0]                 dip_sw,
  output logic                        rom_loaded,
  output logic                        core_reset,
  output logic                        overrun
);

  dl_state_e            state_q;
  dl_state_e            state_n;
  logic [NUM_PORTS-1:0] req_n;
  logic [NUM_PORTS-1:0] hit_q;
  logic [NUM_PORTS-1:0] hit_c;
  logic [WORD_W-1:0]    word_c [NUM_PORTS];
  logic                 wr_q;
  logic                 rom_sel_q;
  logic                 accept_c;
  logic [15:0]          cnt_q;

  logic wr_edge_c;
  logic rom_sel_c;
  logic idle_wr_c;
  assign wr_edge_c = ioctl_wr & ~wr_q;
  assign rom_sel_c = ioctl_download & (ioctl_index == ROM_IDX);
  assign idle_wr_c = wr_edge_c & ioctl_download & (state_q == ST_IDLE);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_win
    dl_window_match #(
      .ADDR_W (ADDR_W),
      .BASE   (PORT_BASE[g]),
      .LIMIT  (PORT_LIMIT[g])
    ) u_win (
      .addr   (ioctl_addr),
      .hit_c  (hit_c[g]),
      .word_c (word_c[g])
    );
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    req_n    = port_req;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_wr_c && (ioctl_index == ROM_IDX) && (hit_c != '0)) begin
          accept_c = 1'b1;
          state_n  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        req_n   = port_req ^ hit_q;
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Only ports that took part in this transfer gate the return to idle.
        if (((port_ack ^ port_req) & hit_q) == '0) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake datapath, side-band captures and loaded/overrun flags.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      rom_sel_q  <= 1'b0;
      port_we    <= 1'b0;
      ioctl_wait <= 1'b0;
      port_req   <= '0;
      hit_q      <= '0;
      port_a     <= '0;
      port_ds    <= '0;
      port_d     <= '0;
      core_mod   <= '0;
      dip_sw     <= '0;
      rom_loaded <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_q       <= ioctl_wr;
      rom_sel_q  <= rom_sel_c;
      port_we    <= ioctl_download;
      ioctl_wait <= (state_n != ST_IDLE);
      port_req   <= req_n;
      if (accept_c) begin
        hit_q   <= hit_c;
        port_ds <= {ioctl_addr[0], ~ioctl_addr[0]};
        port_d  <= {ioctl_dout, ioctl_dout};
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (hit_c[i]) port_a[i*WORD_W +: WORD_W] <= word_c[i];
        end
      end
      if (wr_edge_c && (state_q != ST_IDLE)) overrun <= 1'b1;
      if (rom_sel_q && !rom_sel_c) rom_loaded <= 1'b1;
      if (idle_wr_c && (ioctl_index == MOD_IDX)) core_mod <= ioctl_dout;
      if (idle_wr_c && (ioctl_index == DIP_IDX) && (ioctl_addr[ADDR_W-1:3] == '0))
        dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  // Core reset stretch: reloads while held or not yet loaded, then counts out.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= HOLD;
      core_reset <= 1'b1;
    end else begin
      if (user_reset || !rom_loaded) cnt_q <= HOLD;
      else if (cnt_q != '0)          cnt_q <= cnt_q - 16'd1;
      core_reset <= (cnt_q != '0);
    end
  end

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed plus randomized bench for rom_dl_router with a window/handshake reference model.
module tb_rom_dl_router;

  localparam int unsigned HOLD_T = 20;
  localparam int unsigned NP     = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [1:0]  port_req;
  logic [1:0]  port_ack = 2'b00;
  logic [45:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        port_we;
  logic        user_reset = 1'b0;
  logic [7:0]  core_mod;
  logic [63:0] dip_sw;
  logic        rom_loaded;
  logic        core_reset;
  logic        overrun;

  rom_dl_router #(.HOLD(16'(HOLD_T))) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .port_req(port_req),
    .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds), .port_d(port_d),
    .port_we(port_we), .user_reset(user_reset), .core_mod(core_mod),
    .dip_sw(dip_sw), .rom_loaded(rom_loaded), .core_reset(core_reset),
    .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference state, derived from the window/handshake rules.
  logic [31:0] base_m  [NP] = '{32'h0, 32'h30000};
  logic [31:0] limit_m [NP] = '{32'h9FFFF, 32'h9FFFF};
  logic [1:0]  exp_req = 2'b00;
  logic [22:0] exp_pa [NP] = '{23'd0, 23'd0};
  logic [1:0]  exp_ds = 2'b00;
  logic [15:0] exp_d = 16'h0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"}, 64'(port_req), 64'd0);
    chk({tag, "_wait"}, 64'(ioctl_wait), 64'd0);
    chk({tag, "_we"}, 64'(port_we), 64'd0);
    chk({tag, "_a"}, 64'(port_a), 64'd0);
    chk({tag, "_ds"}, 64'(port_ds), 64'd0);
    chk({tag, "_d"}, 64'(port_d), 64'd0);
    chk({tag, "_mod"}, 64'(core_mod), 64'd0);
    chk({tag, "_dip"}, dip_sw, 64'd0);
    chk({tag, "_loaded"}, 64'(rom_loaded), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
  endtask

  task automatic side_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] v);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = v; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
  endtask

  // One ROM byte: ack for port i is returned d0/d1 cycles into WAIT_ACK.
  task automatic rom_xfer(input logic [24:0] a, input logic [7:0] v, input int d0, input int d1);
    logic [1:0] hit;
    int last;
    for (int i = 0; i < NP; i++)
      hit[i] = (32'(a) >= base_m[i]) && (32'(a) <= limit_m[i]);
    ioctl_index = 8'd0; ioctl_addr = a; ioctl_dout = v; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("wait_after_edge", 64'(ioctl_wait), 64'(hit != 2'b00));
    if (hit == 2'b00) begin
      tick();
      chk("miss_req", 64'(port_req), 64'(exp_req));
      chk("miss_wait", 64'(ioctl_wait), 64'd0);
      return;
    end
    for (int i = 0; i < NP; i++)
      if (hit[i]) exp_pa[i] = 23'((32'(a) - base_m[i]) >> 1);
    exp_ds = {a[0], ~a[0]};
    exp_d = {v, v};
    for (int i = 0; i < NP; i++)
      if (hit[i]) chk("pa_issue", 64'(port_a[i*23 +: 23]), 64'(exp_pa[i]));
    exp_req = exp_req ^ hit;
    tick();
    chk("req_toggle", 64'(port_req), 64'(exp_req));
    chk("ds", 64'(port_ds), 64'(exp_ds));
    chk("d", 64'(port_d), 64'(exp_d));
    chk("wait_held", 64'(ioctl_wait), 64'd1);
    last = 0;
    if (hit[0]) last = d0;
    if (hit[1] && d1 > last) last = d1;
    for (int c = 0; c <= last; c++) begin
      if (hit[0] && c == d0) port_ack[0] = exp_req[0];
      if (hit[1] && c == d1) port_ack[1] = exp_req[1];
      tick();
      chk("wait_ack", 64'(ioctl_wait), 64'(c < last));
      for (int i = 0; i < NP; i++)
        if (hit[i]) chk("pa_stable", 64'(port_a[i*23 +: 23]), 64'(exp_pa[i]));
    end
  endtask

  initial begin
    logic [63:0] exp_dip;
    // Power-on reset, observed before any clock edge.
    #2 reset_n = 1'b0;
    #1 chk_reset_values("por");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Mod and DIP capture.
    ioctl_download = 1'b1;
    side_write(8'd1, 25'd0, 8'h77);
    chk("mod_first", 64'(core_mod), 64'h77);
    side_write(8'd1, 25'd5, 8'h12);
    chk("mod_last_wins", 64'(core_mod), 64'h12);
    exp_dip = 64'h0;
    side_write(8'd254, 25'd3, 8'h5A);
    exp_dip[31:24] = 8'h5A;
    chk("dip_byte3", dip_sw, exp_dip);
    side_write(8'd254, 25'd8, 8'hFF);
    chk("dip_addr8_ignored", dip_sw, exp_dip);
    chk("we_download", 64'(port_we), 64'd1);
    ioctl_download = 1'b0;
    tick();
    chk("loaded_not_rom", 64'(rom_loaded), 64'd0);

    // ROM phase.
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    rom_xfer(25'h00010, 8'hA5, 2, 0);
    chk("p0_word", 64'(port_a[22:0]), 64'h8);
    chk("p0_only_req", 64'(port_req), 64'h1);
    rom_xfer(25'h30001, 8'h3C, 1, 6);
    chk("p1_word_zero", 64'(port_a[45:23]), 64'h0);
    rom_xfer(25'hA0000, 8'h11, 0, 0);

    // Second write edge during WAIT_ACK is discarded and flagged.
    ioctl_addr = 25'h20; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    exp_req[0] = ~exp_req[0];
    ioctl_addr = 25'h44; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    chk("overrun_no_toggle", 64'(port_req), 64'(exp_req));
    chk("overrun_wait", 64'(ioctl_wait), 64'd1);
    chk("overrun_word", 64'(port_a[22:0]), 64'h10);
    port_ack[0] = exp_req[0];
    tick();
    chk("overrun_release", 64'(ioctl_wait), 64'd0);
    tick();
    chk("overrun_req_steady", 64'(port_req), 64'(exp_req));
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Randomized ROM traffic across both windows and the miss region.
    for (int n = 0; n < 24; n++)
      rom_xfer(25'($urandom_range(0, 32'hBFFFF)), 8'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    chk("core_reset_loading", 64'(core_reset), 64'd1);

    // Download ends while WAIT_ACK is pending.
    ioctl_addr = 25'h40; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    exp_req[0] = ~exp_req[0];
    ioctl_download = 1'b0;
    tick();
    chk("loaded_set", 64'(rom_loaded), 64'd1);
    chk("wait_after_dl_end", 64'(ioctl_wait), 64'd1);
    chk("we_dropped", 64'(port_we), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wait_hold_no_ack", 64'(ioctl_wait), 64'd1);
    end
    port_ack[0] = exp_req[0];
    tick();
    chk("wait_release_late", 64'(ioctl_wait), 64'd0);
    for (int k = 4; k < int'(HOLD_T); k++) tick();
    chk("core_reset_hold", 64'(core_reset), 64'd1);
    tick();
    chk("core_reset_fall", 64'(core_reset), 64'd0);

    // User reset pulse restarts the stretch.
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    tick();
    chk("user_reset_rise", 64'(core_reset), 64'd1);
    for (int k = 1; k < int'(HOLD_T); k++) tick();
    chk("user_reset_hold", 64'(core_reset), 64'd1);
    tick();
    chk("user_reset_fall", 64'(core_reset), 64'd0);

    // Reset mid-handshake, then a clean transfer.
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    ioctl_addr = 25'h50; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    chk("pre_reset_wait", 64'(ioctl_wait), 64'd1);
    reset_n = 1'b0;
    port_ack = 2'b00;
    #1 chk_reset_values("mid");
    exp_req = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    rom_xfer(25'h30100, 8'h6E, 3, 1);
    chk("post_reset_req", 64'(port_req), 64'h3);
    chk("post_reset_p1", 64'(port_a[45:23]), 64'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
